imem_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the single combinational 64-word instruction ROM between the processor fetch requester (port 0) and a debug/loader read requester (port 1). It accepts one read per cycle through valid/ready handshakes, drives the ROM address, and registers the returned word into a per-port response held until that port consumes it. It sits between the ROM and its two clients.

---
 rtl/imem_arbiter.sv | 93 +++++++++
 tb/tb_imem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-port round-robin arbiter in front of a combinational instruction ROM.
// One read accepted per cycle; the returned word is held until its port consumes it.
module imem_arbiter #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [N-1:0]  rsp0_data,
  input  logic          rsp0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [N-1:0]  rsp1_data,
  input  logic          rsp1_ready,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_q
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  state_e       state_q, state_d;
  logic         owner_q, owner_d;
  logic [N-1:0] rsp_data_q, rsp_data_d;
  logic         last_grant_q, last_grant_d;

  logic sel;
  logic consume;
  logic free;
  logic accept;

  // State register; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      rsp_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration: a slot being consumed this cycle can be refilled this cycle.
  always_comb begin
    consume = (state_q == S_HOLD) && (owner_q ? rsp1_ready : rsp0_ready);
    free    = (state_q == S_IDLE) || consume;
    if (req0_valid && req1_valid) begin
      sel = !last_grant_q;
    end else if (req1_valid) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    req0_ready = free && req0_valid && !sel;
    req1_ready = free && req1_valid && sel;
    accept     = req0_ready || req1_ready;
    mem_addr   = sel ? req1_addr : req0_addr;
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = S_HOLD;
      owner_d      = sel;
      rsp_data_d   = mem_q;
      last_grant_d = sel;
    end else if (consume) begin
      state_d = S_IDLE;
    end
  end

  // Response outputs decoded from the held slot.
  always_comb begin
    rsp0_valid = (state_q == S_HOLD) && !owner_q;
    rsp1_valid = (state_q == S_HOLD) && owner_q;
    rsp0_data  = rsp_data_q;
    rsp1_data  = rsp_data_q;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 64-word ROM.
module tb_imem_arbiter;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [N-1:0]  rsp0_data, rsp1_data;
  logic          rsp0_ready, rsp1_ready;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_q;
  logic [N-1:0]  rom [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_q = rom[mem_addr];

  imem_arbiter #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .mem_addr(mem_addr), .mem_q(mem_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    rom[0]  = 32'hf8000000;
    rom[1]  = 32'hf8008001;
    rom[14] = 32'hcb0e01ce;
    rom[15] = 32'hb400004e;
    rom[16] = 32'hcb01000f;
    rom[17] = 32'h8b01000f;
    rom[18] = 32'hf803800f;
    rom[40] = 32'h00000000;

    reset = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; rsp1_ready = 1'b0;
    #12;
    check("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("reset_req0_ready", 32'(req0_ready), 32'd0);
    check("reset_req1_ready", 32'(req1_ready), 32'd0);
    check("reset_rsp_data", rsp0_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single port-0 read of addr 0.
    req0_valid = 1'b1; req0_addr = 6'd0; rsp0_ready = 1'b1;
    #1;
    check("p0_req_ready", 32'(req0_ready), 32'd1);
    check("p0_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("p0_rsp_valid", 32'(rsp0_valid), 32'd1);
    check("p0_rsp_data", rsp0_data, 32'hf8000000);
    check("p0_rsp1_quiet", 32'(rsp1_valid), 32'd0);
    tick();
    check("p0_consumed", 32'(rsp0_valid), 32'd0);

    // Port 1 holds its response with rsp1_ready low; port 0 blocked.
    req0_valid = 1'b1; req0_addr = 6'd0;
    req1_valid = 1'b1; req1_addr = 6'd1; rsp1_ready = 1'b0;
    #1;
    check("hold_req1_ready", 32'(req1_ready), 32'd1);
    check("hold_req0_ready_first", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("hold_rsp1_data", rsp1_data, 32'hf8008001);
      check("hold_req0_blocked", 32'(req0_ready), 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check("release_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("release_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("release_rsp0_data", rsp0_data, 32'hf8000000);
    check("release_rsp1_valid", 32'(rsp1_valid), 32'd0);
    tick();

    // Port 0 stream 16,17,18 back to back.
    req0_valid = 1'b1; req0_addr = 6'd16;
    #1;
    check("stream_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_addr = 6'd17;
    #1;
    check("stream_data16", rsp0_data, 32'hcb01000f);
    check("stream_ready1", 32'(req0_ready), 32'd1);
    tick();
    req0_addr = 6'd18;
    #1;
    check("stream_data17", rsp0_data, 32'h8b01000f);
    check("stream_ready2", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("stream_valid18", 32'(rsp0_valid), 32'd1);
    check("stream_data18", rsp0_data, 32'hf803800f);
    tick();

    // Port 1 read of addr 40 (zero word); leaves last_grant at 1.
    req1_valid = 1'b1; req1_addr = 6'd40; rsp1_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    #1;
    check("addr40_valid", 32'(rsp1_valid), 32'd1);
    check("addr40_data", rsp1_data, 32'h0);
    tick();

    // Continuous contention alternates 0,1,0,1.
    req0_valid = 1'b1; req0_addr = 6'd14;
    req1_valid = 1'b1; req1_addr = 6'd15;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_req0_ready", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_req1_ready", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("rr_rsp0_valid", 32'(rsp0_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_rsp1_valid", 32'(rsp1_valid), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_rsp_data", rsp0_data, (i % 2 == 0) ? 32'hcb0e01ce : 32'hb400004e);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Reset during HOLD discards the response immediately.
    req1_valid = 1'b1; req1_addr = 6'd15; rsp1_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    #1;
    check("mid_hold_valid", 32'(rsp1_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_valid", 32'(rsp1_valid), 32'd0);
    check("async_reset_data", rsp1_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 6'd14;
    req1_valid = 1'b1; req1_addr = 6'd15; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("post_reset_tie0", 32'(req0_ready), 32'd1);
    check("post_reset_tie1", 32'(req1_ready), 32'd0);
    tick();
    check("post_reset_data", rsp0_data, 32'hcb0e01ce);
    check("post_reset_valid0", 32'(rsp0_valid), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
